// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the RV32M execute-stage multiply/divide
// unit.
//   - MD_* func3 constants identify the eight RV32M operations.
//   - md_state_t is the iteration FSM encoding (IDLE / CALC / DONE).
//   - Helper functions give the operand signedness and the operation class for
//     a func3 value.
package ex_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  // Number of iteration steps; the step counter runs 0..MD_STEPS-1.
  localparam int MD_STEPS = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op1_signed(input logic [2:0] func3);
    return (func3 == MD_MUL) || (func3 == MD_MULH) || (func3 == MD_MULHSU) ||
           (func3 == MD_DIV) || (func3 == MD_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM.
  function automatic logic op2_signed(input logic [2:0] func3);
    return (func3 == MD_MUL) || (func3 == MD_MULH) ||
           (func3 == MD_DIV) || (func3 == MD_REM);
  endfunction

  // func3[2] separates the divide/remainder group from the multiplies.
  function automatic logic is_div_op(input logic [2:0] func3);
    return func3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_signfix.sv
// md_signfix: combinational conditional two's-complement negation plus the
// RV32M result-selection mux. The top uses two instances:
//   - operand conditioning: produces |rs1| and |rs2|.
//   - output fix: applies the final signs and picks the architectural result.
// Ports:
//   func3      in   3   operation; selects result
//   wide_in    in  64   product, or {32'b0, quotient / operand1}
//   wide_neg   in   1   negate wide_in (modulo 2^64)
//   narrow_in  in  32   remainder, or operand2
//   narrow_neg in   1   negate narrow_in (modulo 2^32)
//   wide_out   out 64   conditionally negated wide_in
//   narrow_out out 32   conditionally negated narrow_in
//   result     out 32   MUL/DIV*: wide_out[31:0], MULH*: wide_out[63:32],
//                       REM*: narrow_out
module md_signfix
  import ex_muldiv_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [63:0] wide_in,
  input  logic        wide_neg,
  input  logic [31:0] narrow_in,
  input  logic        narrow_neg,
  output logic [63:0] wide_out,
  output logic [31:0] narrow_out,
  output logic [31:0] result
);

  always_comb begin
    wide_out   = wide_neg ? (~wide_in + 64'd1) : wide_in;
    narrow_out = narrow_neg ? (~narrow_in + 32'd1) : narrow_in;
    case (func3)
      MD_MUL, MD_DIV, MD_DIVU:       result = wide_out[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = wide_out[63:32];
      MD_REM, MD_REMU:               result = narrow_out;
      default:                       result = narrow_out;
    endcase
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// An accepted request is computed in 32 single-step cycles (shift-add multiply
// or restoring divide on magnitudes), sign-fixed in DONE, and delivered with a
// one-cycle md_done pulse. Divide-by-zero and signed overflow can optionally
// skip the iteration (SPECIAL_FAST).
//
// Handshake: md_start is a request level sampled only in IDLE. While
// md_stall=1 upstream must hold its registers; a request is accepted on the
// clock edge where state=IDLE, md_start=1 and md_flush=0. md_result/md_rd are
// meaningful only in the cycle md_done=1. md_flush cancels any operation in
// flight and suppresses its md_done.
//
// Ports:
//   clk        in   1     core clock
//   rst_n      in   1     asynchronous active-low reset
//   md_start   in   1     operation request (decoded MD_OP)
//   md_func3   in   3     RV32M func3
//   md_op1     in   XLEN  rs1 value
//   md_op2     in   XLEN  rs2 value
//   md_rd_in   in   5     destination register index
//   md_flush   in   1     kill in-flight operation
//   md_stall   out  1     hold decode/execute pipeline registers
//   md_done    out  1     one-cycle result-valid pulse
//   md_result  out  XLEN  result
//   md_rd      out  5     destination register index
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            md_start,
  input  logic [2:0]      md_func3,
  input  logic [XLEN-1:0] md_op1,
  input  logic [XLEN-1:0] md_op2,
  input  logic [4:0]      md_rd_in,
  input  logic            md_flush,
  output logic            md_stall,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic [4:0]      md_rd
);

  md_state_t   state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_reg;      // divide: dividend shifting out, quotient shifting in
  logic [31:0] b_reg;      // |rs2|: multiplicand or divisor
  logic [63:0] acc;        // multiply: {partial product, remaining multiplier}
  logic [32:0] prem;       // divide: partial remainder
  logic [2:0]  func3_reg;
  logic        sign1, sign2;
  logic        dz_reg;     // divisor was zero: quotient keeps all-ones
  logic [4:0]  rd_reg;

  logic        accept;
  logic        s1_in, s2_in;
  logic        zero_div, ovf_div, fast_in;
  logic [63:0] cond_wide;
  logic [31:0] cond_narrow, cond_result;
  logic [31:0] abs1, abs2;

  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic        div_ge;

  logic        run_div;
  logic [63:0] fix_wide_in;
  logic        fix_wide_neg;
  logic [63:0] fix_wide;
  logic [31:0] fix_narrow, fix_result;
  logic        unused_bits;

  // ---------------------------------------------------------------------------
  // Operand conditioning: signs from func3 and the operand MSBs, magnitudes
  // via the shared negate block. |0x80000000| stays 0x80000000, which is the
  // correct unsigned magnitude.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_in    = op1_signed(md_func3) & md_op1[31];
    s2_in    = op2_signed(md_func3) & md_op2[31];
    zero_div = is_div_op(md_func3) && (md_op2 == '0);
    ovf_div  = is_div_op(md_func3) && op2_signed(md_func3) &&
               (md_op1 == 32'h8000_0000) && (md_op2 == 32'hFFFF_FFFF);
    fast_in  = SPECIAL_FAST && (zero_div || ovf_div);
  end

  md_signfix u_cond (
    .func3      (md_func3),
    .wide_in    ({32'b0, md_op1}),
    .wide_neg   (s1_in),
    .narrow_in  (md_op2),
    .narrow_neg (s2_in),
    .wide_out   (cond_wide),
    .narrow_out (cond_narrow),
    .result     (cond_result)
  );

  assign abs1 = cond_wide[31:0];
  assign abs2 = cond_narrow;

  // ---------------------------------------------------------------------------
  // FSM next state and stall.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    md_stall  = 1'b0;
    accept    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (md_start && !md_flush) begin
          accept    = 1'b1;
          md_stall  = 1'b1;
          state_nxt = fast_in ? MD_DONE : MD_CALC;
        end
      end
      MD_CALC: begin
        md_stall = 1'b1;
        if (md_flush)                         state_nxt = MD_IDLE;
        else if (cnt == 5'(MD_STEPS - 1))     state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single iteration step.
  // Multiply: add b_reg into the upper half when the multiplier LSB is set,
  // then shift the whole accumulator right by one.
  // Divide: shift the next dividend bit into the partial remainder and
  // subtract the divisor when it fits; the quotient bit enters a_reg's LSB.
  // ---------------------------------------------------------------------------
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_reg} : 33'd0);
    div_shift = {prem[31:0], a_reg[31]};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_diff  = div_shift - {1'b0, b_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      prem      <= '0;
      func3_reg <= '0;
      sign1     <= 1'b0;
      sign2     <= 1'b0;
      dz_reg    <= 1'b0;
      rd_reg    <= '0;
    end else if (accept) begin
      cnt       <= '0;
      b_reg     <= abs2;
      acc       <= {32'b0, abs1};
      func3_reg <= md_func3;
      sign1     <= s1_in;
      sign2     <= s2_in;
      dz_reg    <= zero_div;
      rd_reg    <= md_rd_in;
      if (fast_in) begin
        // Preload what 32 iterations would leave behind, so DONE is shared.
        a_reg <= zero_div ? 32'hFFFF_FFFF : 32'h8000_0000;
        prem  <= zero_div ? {1'b0, abs1} : 33'd0;
      end else begin
        a_reg <= abs1;
        prem  <= '0;
      end
    end else if (state == MD_CALC) begin
      if (md_flush) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 5'd1;
        if (is_div_op(func3_reg)) begin
          prem  <= div_ge ? div_diff : div_shift;
          a_reg <= {a_reg[30:0], div_ge};
        end else begin
          acc <= {mul_sum, acc[31:1]};
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output fix. A zero divisor makes |rs1| / 0 = all-ones; that quotient must
  // not be negated, while the remainder (= |rs1|) still takes rs1's sign.
  // ---------------------------------------------------------------------------
  always_comb begin
    run_div      = is_div_op(func3_reg);
    fix_wide_in  = run_div ? {32'b0, a_reg} : acc;
    fix_wide_neg = run_div ? ((sign1 ^ sign2) & ~dz_reg) : (sign1 ^ sign2);
  end

  md_signfix u_fix (
    .func3      (func3_reg),
    .wide_in    (fix_wide_in),
    .wide_neg   (fix_wide_neg),
    .narrow_in  (prem[31:0]),
    .narrow_neg (sign1),
    .wide_out   (fix_wide),
    .narrow_out (fix_narrow),
    .result     (fix_result)
  );

  // Intermediate values that only one of the two instances needs.
  assign unused_bits = ^{cond_wide[63:32], cond_result, fix_wide, fix_narrow,
                         prem[32]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_done   <= 1'b0;
      md_result <= '0;
      md_rd     <= '0;
    end else begin
      md_done <= (state == MD_DONE) && !md_flush;
      if ((state == MD_DONE) && !md_flush) begin
        md_result <= fix_result;
        md_rd     <= rd_reg;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  localparam int W = 37;  // {rd, result}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_start = 1'b0;
  logic [2:0]  md_func3 = '0;
  logic [31:0] md_op1 = '0;
  logic [31:0] md_op2 = '0;
  logic [4:0]  md_rd_in = '0;
  logic        md_flush = 1'b0;
  logic        md_stall;
  logic        md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv #(.XLEN(32), .SPECIAL_FAST(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start),
    .md_func3  (md_func3),
    .md_op1    (md_op1),
    .md_op2    (md_op2),
    .md_rd_in  (md_rd_in),
    .md_flush  (md_flush),
    .md_stall  (md_stall),
    .md_done   (md_done),
    .md_result (md_result),
    .md_rd     (md_rd)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  int           n_tests = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every md_done pops one expected {rd, result} and done cycle.
  always @(negedge clk) begin
    if (rst_n && md_done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got md_done=1 at cycle %0d, expected none", cyc);
      end else begin
        logic [W-1:0] e;
        int           l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result", 64'(md_result), 64'(e[31:0]));
        check("rd", 64'(md_rd), 64'(e[36:32]));
        check("done_cycle", 64'(cyc), 64'(l));
      end
    end
    if (rst_n && md_start && (dut.state != MD_IDLE)) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_while_busy: got md_start=1 in state %0d, expected IDLE", dut.state);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp,
                        input bit fast);
    int stalls;
    bit seen;
    @(negedge clk);
    md_func3 = f;
    md_op1   = a;
    md_op2   = b;
    md_rd_in = rd;
    md_start = 1'b1;
    #1;
    stalls = md_stall ? 1 : 0;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    exp_q.push_back({rd, exp});
    lat_q.push_back(cyc + (fast ? 1 : 33));
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_done) begin
        seen = 1'b1;
        break;
      end
      if (md_stall) stalls++;
    end
    check({name, " done_seen"}, 64'(seen), 64'd1);
    check({name, " stall_cycles"}, 64'(stalls), fast ? 64'd1 : 64'd33);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int done_cnt;

    repeat (3) @(negedge clk);
    check("reset done", 64'(md_done), 64'd0);
    check("reset result", 64'(md_result), 64'd0);
    check("reset rd", 64'(md_rd), 64'd0);
    check("reset stall", 64'(md_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7_m3",     MD_MUL,    32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0);
    run_op("mulh_min",     MD_MULH,   32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0);
    run_op("mulhu_min",    MD_MULHU,  32'h8000_0000,  32'h8000_0000, 5'd3,  32'h4000_0000, 1'b0);
    run_op("mulhsu_m1_2",  MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0);
    run_op("mulhu_max",    MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1'b0);
    run_op("mul_max",      MD_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'h0000_0001, 1'b0);
    run_op("divu_100_7",   MD_DIVU,   32'd100,        32'd7,         5'd7,  32'd14,        1'b0);
    run_op("remu_100_7",   MD_REMU,   32'd100,        32'd7,         5'd8,  32'd2,         1'b0);
    run_op("rem_m7_2",     MD_REM,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",     MD_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_2",    MD_DIV,    32'h8000_0000,  32'd2,         5'd11, 32'hC000_0000, 1'b0);
    run_op("divu_max_1",   MD_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd12, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_max_16",  MD_REMU,   32'hFFFF_FFFF,  32'd16,        5'd13, 32'h0000_000F, 1'b0);
    run_op("div_5_0",      MD_DIV,    32'd5,          32'd0,         5'd14, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_5_0",      MD_REM,    32'd5,          32'd0,         5'd15, 32'd5,         1'b1);
    run_op("div_m5_0",     MD_DIV,    32'hFFFF_FFFB,  32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_m5_0",     MD_REM,    32'hFFFF_FFFB,  32'd0,         5'd17, 32'hFFFF_FFFB, 1'b1);
    run_op("divu_min_0",   MD_DIVU,   32'h8000_0000,  32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1);
    run_op("div_ovf",      MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1'b1);
    run_op("rem_ovf",      MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'd0,         1'b1);

    // Flush a DIV at cycle 10: no md_done, stall drops right away.
    @(negedge clk);
    md_func3 = MD_DIV;
    md_op1   = 32'd1000;
    md_op2   = 32'd3;
    md_rd_in = 5'd21;
    md_start = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    md_flush = 1'b1;
    @(posedge clk);
    #1;
    md_flush = 1'b0;
    check("flush stall", 64'(md_stall), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_done) done_cnt++;
    end
    check("flush no_done", 64'(done_cnt), 64'd0);
    run_op("mul_3_4", MD_MUL, 32'd3, 32'd4, 5'd22, 32'd12, 1'b0);

    // Reset at cycle 15 of a DIV.
    @(negedge clk);
    md_func3 = MD_DIV;
    md_op1   = 32'hFFFF_FFFF;
    md_op2   = 32'd7;
    md_rd_in = 5'd23;
    md_start = 1'b1;
    @(posedge clk);
    #1;
    md_start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset done", 64'(md_done), 64'd0);
    check("midreset result", 64'(md_result), 64'd0);
    check("midreset rd", 64'(md_rd), 64'd0);
    check("midreset stall", 64'(md_stall), 64'd0);
    check("midreset state", 64'(dut.state), 64'(MD_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 5'd24, 32'd3, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
